regfile_sweep: RTL and testbench
================================

Name: regfile_sweep

Overview:
- Parametrised successor to the team's fixed 4x8 two-read/one-write register file.
- Generalised in width and depth.
- Adds optional hardwired-zero register 0 and optional write-to-read bypass.
- Adds a multi-cycle clear-sweep state machine with a busy indication, so software can wipe the file without a global reset.
- Sits between the datapath ALU operand muxes (aout/bout) and the result writeback (cin).

Parameters:
- WIDTH, 8, data width of each register.
- AW, 2, select width; depth DEPTH = 2**AW registers.
- ZERO_REG, 0: if 1, register 0 always reads 0 and writes to it are discarded.
- BYPASS, 0: if 1, an accepted write is forwarded combinationally to any read port addressing the same register in the same cycle.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cload  in  1  write enable.
- csel  in  AW  write register select.
- cin  in  WIDTH  write data.
- asel  in  AW  read port A select.
- bsel  in  AW  read port B select.
- clr_req  in  1  request clear sweep (sampled on rising edge).
- aout  out  WIDTH  read port A data (combinational).
- bout  out  WIDTH  read port B data (combinational).
- busy  out  1  registered; 1 while sweep active.
- wr_drop  out  1  combinational; cload & busy, flags a refused write.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - All DEPTH registers = 0; FSM = IDLE; sweep pointer = 0; busy = 0.
  - aout/bout therefore read 0; wr_drop = 0 because busy = 0.
  - Reset asserted mid-sweep aborts the sweep immediately; all registers read 0.
- Write acceptance: accepted = cload & ~busy & ~(ZERO_REG & csel==0).
  - On rising edge with accepted = 1: reg[csel] <= cin.
  - One-cycle write latency; the read sees the new value the cycle after.
- Read: aout = reg[asel]; bout = reg[bsel]; no read latency.
  - ZERO_REG=1: index 0 reads 0 on both ports regardless of stored value.
  - BYPASS=1 and accepted and asel==csel: aout = cin the same cycle. Same rule for bout with bsel.
  - Bypass never overrides the ZERO_REG rule.
  - Both ports addressing the same register both return it.
- FSM states: IDLE, SWEEP.
  - IDLE, clr_req=1 at edge: go to SWEEP, ptr <= 0, busy <= 1. A write accepted in this same edge still lands (busy was 0) and is later cleared by the sweep.
  - SWEEP, each edge: reg[ptr] <= 0, ptr <= ptr+1.
  - SWEEP with ptr==DEPTH-1: clear last register, ptr <= 0 (wrap, no overflow), go to IDLE, busy <= 0.
  - busy is high for exactly DEPTH cycles per sweep.
  - clr_req in SWEEP is ignored (no restart, no queueing).
  - clr_req held high continuously starts a new sweep on the first edge back in IDLE.
  - Writes while busy are discarded; wr_drop=1 for each such cycle.
- Reads during SWEEP return current contents: already-cleared registers read 0, uncleared registers keep old data. Bypass is inactive because accepted=0.
- No X propagation: all selects decode fully for every AW.

Test Plan:
- Reset then write: pulse rst=0, release. Write reg1=0xA5, reg2=0x3C. Set asel=1, bsel=2 -> aout=0xA5, bout=0x3C the cycle after the writes. Before the writes both ports read 0.
- Bypass: BYPASS=1, write csel=3 cin=0x77 while asel=3 -> aout=0x77 in the same cycle. With BYPASS=0 -> aout is the old value (0x00) that cycle, 0x77 the next.
- Zero reg: ZERO_REG=1, write csel=0 cin=0xFF -> aout(asel=0)=0x00 in all later cycles; a write to reg1 is unaffected.
- Sweep (WIDTH=8, AW=2): fill regs 0..3 with 0x11,0x22,0x33,0x44, pulse clr_req.
  - busy=1 for exactly 4 cycles.
  - After 2 sweep edges: reg0=reg1=0, reg2=0x33, reg3=0x44.
  - After the sweep, all read 0.
  - A cload during busy gives wr_drop=1 and the register stays 0.
- Edge cases during sweep: clr_req re-pulsed mid-sweep -> busy still falls after 4 cycles total. rst=0 asserted at sweep cycle 2 -> busy=0 immediately and all registers read 0.
- Width/depth scaling: WIDTH=16, AW=3. Write 0xBEEF to reg7 and reg0 -> both read back correctly. Sweep -> busy=1 for exactly 8 cycles.

Source files
------------

// File: rtl/regfile_sweep_if.sv
// Register file bus: write port, two read ports, clear-sweep control.
interface regfile_sweep_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             cload;
    logic [AW-1:0]    csel;
    logic [WIDTH-1:0] cin;
    logic [AW-1:0]    asel;
    logic [AW-1:0]    bsel;
    logic             clr_req;
    logic [WIDTH-1:0] aout;
    logic [WIDTH-1:0] bout;
    logic             busy;
    logic             wr_drop;

    modport master (
        output cload, csel, cin, asel, bsel, clr_req,
        input  aout, bout, busy, wr_drop
    );

    modport slave (
        input  cload, csel, cin, asel, bsel, clr_req,
        output aout, bout, busy, wr_drop
    );
endinterface

// File: rtl/regfile_sweep.sv
// Parametrised 2-read/1-write register file with optional hardwired zero
// register, optional write-to-read bypass and a multi-cycle clear sweep.
module regfile_sweep #(
    parameter int WIDTH    = 8,
    parameter int AW       = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 0
) (
    input  logic           clk,
    input  logic           rst,
    regfile_sweep_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);
    localparam bit BP    = (BYPASS != 0);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                        state, state_nxt;
    logic   [AW-1:0]               ptr, ptr_nxt;
    logic                          busy_q, busy_nxt;
    logic   [DEPTH-1:0][WIDTH-1:0] regs;
    logic                          accepted;
    logic   [WIDTH-1:0]            aout_v, bout_v;

    // A write lands only when idle and not aimed at a hardwired-zero reg0.
    assign accepted    = bus.cload & ~busy_q & ~(ZR & (bus.csel == '0));
    assign bus.busy    = busy_q;
    assign bus.wr_drop = bus.cload & busy_q;
    assign bus.aout    = aout_v;
    assign bus.bout    = bout_v;

    // FSM state, sweep pointer and registered busy flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            busy_q <= busy_nxt;
        end
    end

    // Next-state: a sweep visits every register once, then returns to idle;
    // clr_req is ignored while sweeping so there is no restart or queueing.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = busy_q;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    state_nxt = SWEEP;
                    ptr_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            SWEEP: begin
                ptr_nxt = ptr + 1'b1;  // wraps to 0 after LAST
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                ptr_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // Storage: sweep clears one entry per cycle, otherwise accepted writes land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '0;
        end else if (state == SWEEP) begin
            regs[ptr] <= '0;
        end else if (accepted) begin
            regs[bus.csel] <= bus.cin;
        end
    end

    // Read port A: stored value, then bypass, then zero-register override.
    always_comb begin
        aout_v = regs[bus.asel];
        if (BP && accepted && (bus.asel == bus.csel)) aout_v = bus.cin;
        if (ZR && (bus.asel == '0))                   aout_v = '0;
    end

    // Read port B: same priority as port A.
    always_comb begin
        bout_v = regs[bus.bsel];
        if (BP && accepted && (bus.bsel == bus.csel)) bout_v = bus.cin;
        if (ZR && (bus.bsel == '0))                   bout_v = '0;
    end
endmodule

// File: tb/tb_regfile_sweep.sv
// Directed bench: a default 8x4 file (u0) and a zero-reg+bypass 8x4 file (u1)
// share stimulus from a vector table; a 16x8 file (u2) covers scaling.
module tb_regfile_sweep;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus for u0/u1
    logic       cload = 1'b0, clr_req = 1'b0;
    logic [1:0] csel = '0, asel = '0, bsel = '0;
    logic [7:0] cin = '0;
    // stimulus for u2
    logic        w_cload = 1'b0, w_clr = 1'b0;
    logic [2:0]  w_csel = '0, w_asel = '0, w_bsel = '0;
    logic [15:0] w_cin = '0;

    regfile_sweep_if #(.WIDTH(8),  .AW(2)) if0 ();
    regfile_sweep_if #(.WIDTH(8),  .AW(2)) if1 ();
    regfile_sweep_if #(.WIDTH(16), .AW(3)) if2 ();

    assign if0.cload = cload;   assign if1.cload = cload;
    assign if0.csel  = csel;    assign if1.csel  = csel;
    assign if0.cin   = cin;     assign if1.cin   = cin;
    assign if0.asel  = asel;    assign if1.asel  = asel;
    assign if0.bsel  = bsel;    assign if1.bsel  = bsel;
    assign if0.clr_req = clr_req; assign if1.clr_req = clr_req;
    assign if2.cload = w_cload;
    assign if2.csel  = w_csel;
    assign if2.cin   = w_cin;
    assign if2.asel  = w_asel;
    assign if2.bsel  = w_bsel;
    assign if2.clr_req = w_clr;

    regfile_sweep #(.WIDTH(8), .AW(2), .ZERO_REG(0), .BYPASS(0))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    regfile_sweep #(.WIDTH(8), .AW(2), .ZERO_REG(1), .BYPASS(1))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    regfile_sweep #(.WIDTH(16), .AW(3), .ZERO_REG(0), .BYPASS(0))
        u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       cl;
        logic [1:0] cs;
        logic [7:0] cd;
        logic [1:0] as_;
        logic [1:0] bs;
        logic       clr;
        logic [7:0] a0, b0, a1, b1;
        logic       busy, drop;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic cl, logic [1:0] cs, logic [7:0] cd,
                                logic [1:0] as_, logic [1:0] bs, logic clr,
                                logic [7:0] a0, logic [7:0] b0,
                                logic [7:0] a1, logic [7:0] b1,
                                logic busy, logic drop);
        vec_t v;
        v.cl = cl; v.cs = cs; v.cd = cd; v.as_ = as_; v.bs = bs; v.clr = clr;
        v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1; v.busy = busy; v.drop = drop;
        return v;
    endfunction

    int cnt;
    logic seen;

    initial begin
        // One vector per cycle: inputs driven just after an edge, outputs
        // checked at the falling edge, the following rising edge commits.
        //            cl cs cin    as bs clr  a0     b0     a1     b1    busy drop
        vt.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vt.push_back(mk(1, 1, 8'hA5, 1, 2, 0, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 0));
        vt.push_back(mk(1, 2, 8'h3C, 1, 2, 0, 8'hA5, 8'h00, 8'hA5, 8'h3C, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 1, 2, 0, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 0));
        vt.push_back(mk(1, 3, 8'h77, 3, 3, 0, 8'h00, 8'h00, 8'h77, 8'h77, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 3, 1, 0, 8'h77, 8'hA5, 8'h77, 8'hA5, 0, 0));
        vt.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 3, 0, 8'hFF, 8'h77, 8'h00, 8'h77, 0, 0));
        vt.push_back(mk(1, 0, 8'h11, 0, 1, 0, 8'hFF, 8'hA5, 8'h00, 8'hA5, 0, 0));
        vt.push_back(mk(1, 1, 8'h22, 0, 1, 0, 8'h11, 8'hA5, 8'h00, 8'h22, 0, 0));
        vt.push_back(mk(1, 2, 8'h33, 1, 2, 0, 8'h22, 8'h3C, 8'h22, 8'h33, 0, 0));
        // write to reg3 lands on the same edge the sweep starts
        vt.push_back(mk(1, 3, 8'h44, 2, 3, 1, 8'h33, 8'h77, 8'h33, 8'h44, 0, 0));
        // sweep cycles 1..4; writes refused, no bypass
        vt.push_back(mk(1, 3, 8'h99, 0, 3, 0, 8'h11, 8'h44, 8'h00, 8'h44, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'h00, 8'h22, 8'h00, 8'h22, 1, 0));
        vt.push_back(mk(1, 1, 8'h55, 1, 2, 0, 8'h00, 8'h33, 8'h00, 8'h33, 1, 1));
        vt.push_back(mk(0, 0, 8'h00, 2, 3, 0, 8'h00, 8'h44, 8'h00, 8'h44, 1, 0));
        // sweep done, refused writes left nothing behind
        vt.push_back(mk(0, 0, 8'h00, 3, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        // clr_req held high: back-to-back sweeps with one idle cycle between
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 0));
        vt.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0));

        // reset state (cload high to show wr_drop stays low)
        cload = 1'b1; asel = 2'd1; bsel = 2'd2;
        #12;
        chk("rst busy", {15'd0, if0.busy}, 16'd0);
        chk("rst drop", {15'd0, if0.wr_drop}, 16'd0);
        chk("rst aout", {8'd0, if0.aout}, 16'd0);
        chk("rst bout", {8'd0, if0.bout}, 16'd0);
        chk("rst u2 busy", {15'd0, if2.busy}, 16'd0);
        cload = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            @(posedge clk);
            #1;
            cload = vt[i].cl; csel = vt[i].cs; cin = vt[i].cd;
            asel = vt[i].as_; bsel = vt[i].bs; clr_req = vt[i].clr;
            @(negedge clk);
            chk($sformatf("v%0d u0 aout", i), {8'd0, if0.aout}, {8'd0, vt[i].a0});
            chk($sformatf("v%0d u0 bout", i), {8'd0, if0.bout}, {8'd0, vt[i].b0});
            chk($sformatf("v%0d u1 aout", i), {8'd0, if1.aout}, {8'd0, vt[i].a1});
            chk($sformatf("v%0d u1 bout", i), {8'd0, if1.bout}, {8'd0, vt[i].b1});
            chk($sformatf("v%0d busy", i), {15'd0, if0.busy}, {15'd0, vt[i].busy});
            chk($sformatf("v%0d u1 busy", i), {15'd0, if1.busy}, {15'd0, vt[i].busy});
            chk($sformatf("v%0d drop", i), {15'd0, if0.wr_drop}, {15'd0, vt[i].drop});
        end

        // Reset in the middle of a sweep: load reg2/reg3, start sweep,
        // assert reset after the second sweep cycle has begun.
        @(posedge clk); #1;
        cload = 1'b1; csel = 2'd2; cin = 8'h5A; clr_req = 1'b0;
        @(posedge clk); #1;
        csel = 2'd3; cin = 8'hC3;
        @(posedge clk); #1;
        cload = 1'b0; clr_req = 1'b1;
        @(posedge clk); #1;          // sweep cycle 1
        clr_req = 1'b0;
        @(posedge clk); #1;          // sweep cycle 2: reg0 cleared, reg2/3 intact
        asel = 2'd2; bsel = 2'd3;
        #1;
        chk("mid busy", {15'd0, if0.busy}, 16'd1);
        chk("mid reg2", {8'd0, if0.aout}, 16'h005A);
        chk("mid reg3", {8'd0, if0.bout}, 16'h00C3);
        #1;
        rst = 1'b0;
        #1;
        chk("abort busy", {15'd0, if0.busy}, 16'd0);
        for (int a = 0; a < 4; a++) begin
            asel = 2'(a); bsel = 2'(3 - a);
            #1;
            chk($sformatf("abort a%0d", a), {8'd0, if0.aout}, 16'd0);
            chk($sformatf("abort b%0d", 3 - a), {8'd0, if0.bout}, 16'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post abort busy", {15'd0, if0.busy}, 16'd0);

        // 16-bit x 8 file: extremes of the address range, then a full sweep.
        @(posedge clk); #1;
        w_cload = 1'b1; w_csel = 3'd7; w_cin = 16'hBEEF;
        @(posedge clk); #1;
        w_csel = 3'd0;
        @(posedge clk); #1;
        w_cload = 1'b0; w_asel = 3'd7; w_bsel = 3'd0;
        @(negedge clk);
        chk("w reg7", if2.aout, 16'hBEEF);
        chk("w reg0", if2.bout, 16'hBEEF);
        @(posedge clk); #1;
        w_clr = 1'b1;
        @(posedge clk); #1;
        w_clr = 1'b0;
        cnt = 0; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (if2.busy) begin
                cnt++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        chk("w busy cycles", 16'(cnt), 16'd8);
        chk("w reg7 swept", if2.aout, 16'h0000);
        chk("w reg0 swept", if2.bout, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
